// File: rtl/uop_issue_scheduler.sv
// One-entry in-order issue stage: routes integer uops to the ALU and multiply uops to a
// pipelined multiplier, resolving RAW/WAW/flag hazards and register-file write-port conflicts.
module uop_issue_scheduler #(
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [3:0]       in_class_i,
   input  logic [3:0]       in_cond_i,
   input  logic [3:0]       in_dest_i,
   input  logic             in_wr_dest_i,
   input  logic             in_wr_cpsr_i,
   input  logic [11:0]      in_src_i,
   input  logic [2:0]       in_src_use_i,
   output logic             int_issue_o,
   output logic             mul_issue_o,
   output logic [3:0]       iss_dest_o,
   output logic [11:0]      iss_src_o,
   output logic             mul_wb_o,
   output logic [3:0]       mul_wb_dest_o,
   output logic             drop_o,
   output logic [CNT_W-1:0] stall_cnt_o
);
   localparam logic [3:0] UOP_INTEGER   = 4'd1;
   localparam logic [3:0] UOP_INTEGER_M = 4'd2;
   localparam logic [3:0] COND_AL       = 4'b1110;

   typedef enum logic {IDLE, BUSY} mul_state_e;

   logic             ir_valid_q, ir_valid_d;
   logic [3:0]       ir_class_q, ir_class_d;
   logic [3:0]       ir_cond_q, ir_cond_d;
   logic [3:0]       ir_dest_q, ir_dest_d;
   logic             ir_wr_dest_q, ir_wr_dest_d;
   logic             ir_wr_cpsr_q, ir_wr_cpsr_d;
   logic [11:0]      ir_src_q, ir_src_d;
   logic [2:0]       ir_src_use_q, ir_src_use_d;
   logic [15:0]      sb_q, sb_d;
   logic             cpsr_pend_q, cpsr_pend_d;
   mul_state_e       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0]       mul_dest_q, mul_dest_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic [15:0] haz;
   logic        raw, waw, cflag, hazard_free, issue;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir_valid_q   <= 1'b0;
         ir_class_q   <= '0;
         ir_cond_q    <= '0;
         ir_dest_q    <= '0;
         ir_wr_dest_q <= 1'b0;
         ir_wr_cpsr_q <= 1'b0;
         ir_src_q     <= '0;
         ir_src_use_q <= '0;
         sb_q         <= '0;
         cpsr_pend_q  <= 1'b0;
         state_q      <= IDLE;
         cnt_q        <= '0;
         mul_dest_q   <= '0;
         stall_q      <= '0;
      end else begin
         ir_valid_q   <= ir_valid_d;
         ir_class_q   <= ir_class_d;
         ir_cond_q    <= ir_cond_d;
         ir_dest_q    <= ir_dest_d;
         ir_wr_dest_q <= ir_wr_dest_d;
         ir_wr_cpsr_q <= ir_wr_cpsr_d;
         ir_src_q     <= ir_src_d;
         ir_src_use_q <= ir_src_use_d;
         sb_q         <= sb_d;
         cpsr_pend_q  <= cpsr_pend_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mul_dest_q   <= mul_dest_d;
         stall_q      <= stall_d;
      end
   end

   assign mul_wb_o      = (state_q == BUSY) && (cnt_q == 4'd1);
   assign mul_wb_dest_o = mul_dest_q;

   // A register completing this cycle is bypassed, so it no longer blocks readers or writers.
   assign haz = sb_q & ~(mul_wb_o ? (16'h1 << mul_dest_q) : 16'h0);

   assign raw = (ir_src_use_q[0] && haz[ir_src_q[3:0]])  ||
                (ir_src_use_q[1] && haz[ir_src_q[7:4]])  ||
                (ir_src_use_q[2] && haz[ir_src_q[11:8]]);
   assign waw         = ir_wr_dest_q && haz[ir_dest_q];
   assign cflag       = (ir_cond_q != COND_AL) && cpsr_pend_q;
   assign hazard_free = ir_valid_q && !raw && !waw && !cflag;

   assign int_issue_o = hazard_free && (ir_class_q == UOP_INTEGER) && (cnt_q != 4'd2);
   assign mul_issue_o = hazard_free && (ir_class_q == UOP_INTEGER_M) &&
                        ((state_q == IDLE) || (cnt_q == 4'd1));
   assign drop_o      = ir_valid_q && (ir_class_q != UOP_INTEGER) && (ir_class_q != UOP_INTEGER_M);
   assign issue       = int_issue_o || mul_issue_o;
   assign in_ready_o  = !ir_valid_q || issue || drop_o;
   assign iss_dest_o  = ir_dest_q;
   assign iss_src_o   = ir_src_q;
   assign stall_cnt_o = stall_q;

   always_comb begin
      ir_valid_d   = ir_valid_q;
      ir_class_d   = ir_class_q;
      ir_cond_d    = ir_cond_q;
      ir_dest_d    = ir_dest_q;
      ir_wr_dest_d = ir_wr_dest_q;
      ir_wr_cpsr_d = ir_wr_cpsr_q;
      ir_src_d     = ir_src_q;
      ir_src_use_d = ir_src_use_q;
      if (flush_i) begin
         ir_valid_d = 1'b0;
      end else if (in_valid_i && in_ready_o) begin
         ir_valid_d   = 1'b1;
         ir_class_d   = in_class_i;
         ir_cond_d    = in_cond_i;
         ir_dest_d    = in_dest_i;
         ir_wr_dest_d = in_wr_dest_i;
         ir_wr_cpsr_d = in_wr_cpsr_i;
         ir_src_d     = in_src_i;
         ir_src_use_d = in_src_use_i;
      end else if (issue || drop_o) begin
         ir_valid_d = 1'b0;
      end

      cpsr_pend_d = !flush_i && int_issue_o && ir_wr_cpsr_q;

      stall_d = stall_q;
      if (ir_valid_q && !issue && !drop_o && !flush_i && !(&stall_q))
         stall_d = stall_q + 1'b1;
   end

   // Multiplier tracking: a back-to-back issue in the completion cycle reloads the counter.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mul_dest_d = mul_dest_q;
      sb_d       = sb_q;
      if (mul_issue_o) begin
         if (mul_wb_o)
            sb_d[mul_dest_q] = 1'b0;
         if (ir_wr_dest_q)
            sb_d[ir_dest_q] = 1'b1;
         state_d    = BUSY;
         cnt_d      = 4'(MUL_LAT);
         mul_dest_d = ir_dest_q;
      end else if (state_q == BUSY) begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            state_d          = IDLE;
            sb_d[mul_dest_q] = 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uop_issue_scheduler.sv
// Bench for uop_issue_scheduler: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_uop_issue_scheduler;
   localparam int LAT   = 4;
   localparam int CNT_W = 16;
   localparam logic [3:0] C_BR = 4'd0, C_INT = 4'd1, C_MUL = 4'd2, C_LD = 4'd3, C_FP = 4'd5;

   logic clk = 1'b0, rst = 1'b1, flush_i = 1'b0, in_valid_i = 1'b0;
   logic [3:0] in_class_i = '0, in_cond_i = 4'hE, in_dest_i = '0;
   logic in_wr_dest_i = 1'b0, in_wr_cpsr_i = 1'b0;
   logic [11:0] in_src_i = '0;
   logic [2:0] in_src_use_i = '0;
   logic in_ready_o, int_issue_o, mul_issue_o, mul_wb_o, drop_o;
   logic [3:0] iss_dest_o, mul_wb_dest_o;
   logic [11:0] iss_src_o;
   logic [CNT_W-1:0] stall_cnt_o;

   uop_issue_scheduler #(.MUL_LAT(LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_class_i(in_class_i), .in_cond_i(in_cond_i), .in_dest_i(in_dest_i),
      .in_wr_dest_i(in_wr_dest_i), .in_wr_cpsr_i(in_wr_cpsr_i), .in_src_i(in_src_i),
      .in_src_use_i(in_src_use_i), .int_issue_o(int_issue_o), .mul_issue_o(mul_issue_o),
      .iss_dest_o(iss_dest_o), .iss_src_o(iss_src_o), .mul_wb_o(mul_wb_o),
      .mul_wb_dest_o(mul_wb_dest_o), .drop_o(drop_o), .stall_cnt_o(stall_cnt_o));

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: the held uop, a 1-cycle flag bit, and at most one in-flight multiply
   // described by its issue timestamp.
   logic        m_v, m_wd, m_wc, m_cp, mul_v, mul_w;
   logic [3:0]  m_cls, m_cond, m_dst, mul_d;
   logic [11:0] m_src;
   logic [2:0]  m_use;
   int          cyc, mul_t, m_stall;

   logic e_wb, e_wb_next, e_free, e_int, e_mul, e_drop, e_ready, ok;
   function automatic logic busy_reg(input logic [3:0] r, input logic wb);
      return mul_v && mul_w && (mul_d == r) && !wb;
   endfunction

   always_comb begin
      e_wb      = mul_v && (cyc == mul_t + LAT);
      e_wb_next = mul_v && (cyc + 1 == mul_t + LAT);
      e_free    = !mul_v || e_wb;
      ok = m_v && !(m_use[0] && busy_reg(m_src[3:0], e_wb))
               && !(m_use[1] && busy_reg(m_src[7:4], e_wb))
               && !(m_use[2] && busy_reg(m_src[11:8], e_wb))
               && !(m_wd && busy_reg(m_dst, e_wb))
               && !(m_cond != 4'hE && m_cp);
      e_int   = ok && m_cls == C_INT && !e_wb_next;
      e_mul   = ok && m_cls == C_MUL && e_free;
      e_drop  = m_v && m_cls != C_INT && m_cls != C_MUL;
      e_ready = !m_v || e_int || e_mul || e_drop;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_v <= 1'b0; m_cp <= 1'b0; mul_v <= 1'b0; m_stall <= 0; cyc <= 0;
      end else begin
         if (e_mul) begin
            mul_v <= 1'b1; mul_t <= cyc; mul_d <= m_dst; mul_w <= m_wd;
         end else if (e_wb) mul_v <= 1'b0;
         m_cp <= !flush_i && e_int && m_wc;
         if (m_v && !e_int && !e_mul && !e_drop && !flush_i && m_stall < (1 << CNT_W) - 1)
            m_stall <= m_stall + 1;
         if (flush_i) m_v <= 1'b0;
         else if (in_valid_i && e_ready) begin
            m_v <= 1'b1; m_cls <= in_class_i; m_cond <= in_cond_i; m_dst <= in_dest_i;
            m_wd <= in_wr_dest_i; m_wc <= in_wr_cpsr_i; m_src <= in_src_i; m_use <= in_src_use_i;
         end else if (e_int || e_mul || e_drop) m_v <= 1'b0;
         cyc <= cyc + 1;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", in_ready_o, e_ready);
         chk("int_issue", int_issue_o, e_int);
         chk("mul_issue", mul_issue_o, e_mul);
         chk("drop", drop_o, e_drop);
         chk("mul_wb", mul_wb_o, e_wb);
         chk("stall_cnt", stall_cnt_o, m_stall);
         if (e_int || e_mul) begin
            chk("iss_dest", iss_dest_o, m_dst);
            chk("iss_src", iss_src_o, m_src);
         end
         if (e_wb) chk("mul_wb_dest", mul_wb_dest_o, mul_d);
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic put(input logic [3:0] c, input logic [3:0] cd, input logic [3:0] d,
                      input logic wd, input logic wc, input logic [11:0] s, input logic [2:0] u);
      in_valid_i = 1'b1; in_class_i = c; in_cond_i = cd; in_dest_i = d;
      in_wr_dest_i = wd; in_wr_cpsr_i = wc; in_src_i = s; in_src_use_i = u;
   endtask

   task automatic idle();
      in_valid_i = 1'b0;
   endtask

   initial begin
      step(); #1;
      chk("rst_ready", in_ready_o, 1); chk("rst_int", int_issue_o, 0);
      chk("rst_mul", mul_issue_o, 0);  chk("rst_wb", mul_wb_o, 0);
      chk("rst_drop", drop_o, 0);      chk("rst_stall", stall_cnt_o, 0);

      // ADD r1 issues the cycle after acceptance
      do_reset();
      put(C_INT, 4'hE, 4'd1, 1, 0, 12'h000, 3'b000); #1 chk("t1_ready0", in_ready_o, 1);
      step(); idle();
      chk("t1_int", int_issue_o, 1); chk("t1_dest", iss_dest_o, 1); chk("t1_ready1", in_ready_o, 1);

      // MUL r2 then dependent ADD r3 bypasses on the writeback cycle
      do_reset();
      put(C_MUL, 4'hE, 4'd2, 1, 0, 12'h000, 3'b000);
      step(); chk("t2_mul", mul_issue_o, 1);
      put(C_INT, 4'hE, 4'd3, 1, 0, 12'h002, 3'b001); #1 chk("t2_ready", in_ready_o, 1);
      step(); idle(); chk("t2_hold2", int_issue_o, 0);
      step(); step(); chk("t2_hold4", int_issue_o, 0);
      step();
      chk("t2_wb", mul_wb_o, 1); chk("t2_wbd", mul_wb_dest_o, 2);
      chk("t2_int", int_issue_o, 1); chk("t2_stall", stall_cnt_o, 3);

      // independent ADD held exactly once, on the cycle before the multiply writeback
      do_reset();
      put(C_MUL, 4'hE, 4'd2, 1, 0, 12'h000, 3'b000);
      step(); idle(); chk("t3_mul", mul_issue_o, 1);
      step(); step(); put(C_INT, 4'hE, 4'd4, 1, 0, 12'h005, 3'b001);
      step(); idle(); chk("t3_hold", int_issue_o, 0);
      step(); chk("t3_int", int_issue_o, 1); chk("t3_wb", mul_wb_o, 1);
      chk("t3_stall", stall_cnt_o, 1);

      // CMP then ADDEQ waits one cycle; ADDAL does not
      do_reset();
      put(C_INT, 4'hE, 4'd0, 0, 1, 12'h000, 3'b000);
      step(); chk("t4_cmp", int_issue_o, 1);
      put(C_INT, 4'h0, 4'd5, 1, 0, 12'h000, 3'b000);
      step(); idle(); chk("t4_eq_hold", int_issue_o, 0);
      step(); chk("t4_eq_iss", int_issue_o, 1);
      do_reset();
      put(C_INT, 4'hE, 4'd0, 0, 1, 12'h000, 3'b000);
      step(); put(C_INT, 4'hE, 4'd5, 1, 0, 12'h000, 3'b000);
      step(); idle(); chk("t4_al_iss", int_issue_o, 1);

      // back-to-back MUL r2: second issues on the first writeback cycle
      do_reset();
      put(C_MUL, 4'hE, 4'd2, 1, 0, 12'h000, 3'b000);
      step(); chk("t5_mul1", mul_issue_o, 1);
      step(); idle(); chk("t5_waw", mul_issue_o, 0);
      step(); step(); step();
      chk("t5_mul2", mul_issue_o, 1); chk("t5_wb1", mul_wb_o, 1);
      put(C_INT, 4'hE, 4'd3, 1, 0, 12'h002, 3'b001);
      step(); idle(); chk("t5_sb_set", int_issue_o, 0);
      step(); step(); step();
      chk("t5_wb2", mul_wb_o, 1); chk("t5_int", int_issue_o, 1);

      // drop of a load, flush of a held ADD, multiply still completes
      do_reset();
      put(C_MUL, 4'hE, 4'd2, 1, 0, 12'h000, 3'b000);
      step(); chk("t6_mul", mul_issue_o, 1);
      put(C_LD, 4'hE, 4'd9, 1, 0, 12'h000, 3'b000);
      step(); chk("t6_drop", drop_o, 1); chk("t6_ready", in_ready_o, 1);
      put(C_INT, 4'hE, 4'd5, 1, 0, 12'h002, 3'b001);
      step(); idle(); chk("t6_nodrop", drop_o, 0); chk("t6_held", int_issue_o, 0);
      flush_i = 1'b1;
      step(); flush_i = 1'b0;
      chk("t6_flushed", in_ready_o, 1); chk("t6_fl_stall", stall_cnt_o, 0);
      step(); chk("t6_wb", mul_wb_o, 1); chk("t6_wbd", mul_wb_dest_o, 2);

      // reset mid-multiply: no writeback, scoreboard cleared
      do_reset();
      put(C_MUL, 4'hE, 4'd7, 1, 0, 12'h000, 3'b000);
      step(); idle(); chk("t6r_mul", mul_issue_o, 1);
      step(); rst = 1'b1; step(); rst = 1'b0;
      put(C_INT, 4'hE, 4'd1, 1, 0, 12'h007, 3'b001);
      step(); idle(); chk("t6r_int", int_issue_o, 1);
      for (int i = 0; i < 6; i++) begin
         chk("t6r_nowb", mul_wb_o, 0); step();
      end

      // randomized soak
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         int r;
         logic [3:0] c;
         r = $urandom_range(0, 9);
         c = (r < 4) ? C_INT : (r < 7) ? C_MUL : (r == 7) ? C_LD : (r == 8) ? C_BR : C_FP;
         if ($urandom_range(0, 9) < 7)
            put(c, ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0),
                {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
                3'($urandom_range(0, 7)));
         else idle();
         flush_i = ($urandom_range(0, 99) < 3);
         rst = ($urandom_range(0, 999) < 3);
         step();
      end
      rst = 1'b0; flush_i = 1'b0; idle();
      step(); step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
